conv_encoder: RTL

Rate-1/2, constraint-length-4 convolutional encoder. It generates the coded symbol stream that the Viterbi decoder's branch-metric, ACS and traceback path consumes. Its 3-bit shift register advances through the decoder's 8-state trellis, with next state = {state[1:0], bit}. Frames are accepted bit-serially over a valid/ready handshake; zero tail bits are optionally appended so every frame terminates in state 0.

---
 rtl/conv_encoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/conv_encoder.sv
// Rate-1/2 K=4 convolutional encoder (G0=1101, G1=1111), bit-serial in.
// Define CONV_ENC_TAIL_EN to append three zero tail bits per frame.
module conv_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_sym,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] G0 = 4'b1101;
  localparam logic [3:0] G1 = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FLUSH
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sr_q, sr_d;
  logic       ov_q, ov_d;
  logic [1:0] sym_q, sym_d;
  logic       last_q, last_d;
  logic       busy_q, busy_d;
`ifdef CONV_ENC_TAIL_EN
  logic [1:0] tail_q, tail_d;
`endif

  logic       free;
  logic       flush;
  logic       acc;
  logic       din;
  logic [3:0] taps;
  logic [1:0] sym;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    ov_d    = ov_q;
    sym_d   = sym_q;
    last_d  = last_q;
    busy_d  = busy_q;
`ifdef CONV_ENC_TAIL_EN
    tail_d  = tail_q;
`endif
    free     = !ov_q || out_ready;
    flush    = (state_q == FLUSH);
    in_ready = rst && !flush && free;
    acc      = in_valid && in_ready;
    din      = flush ? 1'b0 : in_data;
    taps     = {din, sr_q[0], sr_q[1], sr_q[2]};
    sym      = {^(G1 & taps), ^(G0 & taps)};

    if (ov_q && out_ready) begin
      ov_d   = 1'b0;
      last_d = 1'b0;
      if (last_q) busy_d = 1'b0;
    end

    unique case (state_q)
      IDLE, DATA: begin
        if (acc) begin
          ov_d    = 1'b1;
          sym_d   = sym;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          sr_d    = {sr_q[1:0], din};
          state_d = DATA;
          if (in_last) begin
`ifdef CONV_ENC_TAIL_EN
            state_d = FLUSH;
            tail_d  = 2'd0;
`else
            // Truncated frame: restart the trellis at state 0
            last_d  = 1'b1;
            sr_d    = 3'b000;
            state_d = IDLE;
`endif
          end
        end
      end
      FLUSH: begin
`ifdef CONV_ENC_TAIL_EN
        if (tail_q != 2'd3) begin
          if (free) begin
            ov_d   = 1'b1;
            sym_d  = sym;
            last_d = (tail_q == 2'd2);
            sr_d   = {sr_q[1:0], din};
            tail_d = tail_q + 2'd1;
          end
        end else if (ov_q && out_ready) begin
          // Hold FLUSH until out_last leaves so a new bit cannot overlap it
          state_d = IDLE;
          tail_d  = 2'd0;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= 3'b000;
      ov_q    <= 1'b0;
      sym_q   <= 2'b00;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      tail_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      ov_q    <= ov_d;
      sym_q   <= sym_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef CONV_ENC_TAIL_EN
      tail_q  <= tail_d;
`endif
    end
  end

  assign out_valid = ov_q;
  assign out_sym   = sym_q;
  assign out_last  = last_q;
  assign busy      = busy_q;

endmodule
